// File: rtl/twenty48_pkg.sv
// Shared types and constants for the 2048 game datapath.
// Direction codes, the 3-bit direction type, ASCII keys, WASD decode.
package twenty48_pkg;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_UP    = 3'd0;
  localparam dir_t DIR_RIGHT = 3'd1;
  localparam dir_t DIR_DOWN  = 3'd2;
  localparam dir_t DIR_LEFT  = 3'd3;
  localparam dir_t DIR_NONE  = 3'd4;

  localparam logic [7:0] KEY_ESC = 8'h1B;
  localparam logic [7:0] KEY_CSI = 8'h5B;

  function automatic dir_t wasd_dir(
    input logic [7:0] b
  );
    dir_t d;
    d = DIR_NONE;
    case (b)
      8'h77, 8'h57: d = DIR_UP;
      8'h64, 8'h44: d = DIR_RIGHT;
      8'h73, 8'h53: d = DIR_DOWN;
      8'h61, 8'h41: d = DIR_LEFT;
      default:      d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic dir_t arrow_dir(
    input logic [7:0] b
  );
    dir_t d;
    d = DIR_NONE;
    case (b)
      8'h41:   d = DIR_UP;
      8'h42:   d = DIR_DOWN;
      8'h43:   d = DIR_RIGHT;
      8'h44:   d = DIR_LEFT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

  function automatic logic is_new_key(
    input logic [7:0] b
  );
    return (b == 8'h72) || (b == 8'h52);
  endfunction

endpackage

// File: rtl/uart_key_parser.sv
// UART keystroke parser: WASD/R keys and ESC [ A..D arrow sequences.
// Ports: clk, rst (async low), rx_data/rx_valid in; cmd_valid/cmd_new/cmd_dir out (comb).
module uart_key_parser
  import twenty48_pkg::*;
#(
  parameter int ESC_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic       cmd_new,
  output dir_t       cmd_dir
);

  localparam int TW = $clog2(ESC_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ESC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    P_IDLE,
    P_ESC,
    P_CSI
  } pstate_t;

  pstate_t       state;
  pstate_t       state_nx;
  logic [TW-1:0] tmo;
  logic [TW-1:0] tmo_nx;
  dir_t          kdir;
  dir_t          adir;

  assign kdir = wasd_dir(rx_data);
  assign adir = arrow_dir(rx_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= P_IDLE;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      tmo   <= tmo_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    tmo_nx    = tmo;
    cmd_valid = 1'b0;
    cmd_new   = 1'b0;
    cmd_dir   = DIR_NONE;
    unique case (state)
      P_IDLE: begin
        tmo_nx = '0;
        if (rx_valid) begin
          if (rx_data == KEY_ESC) begin
            state_nx = P_ESC;
          end else if (is_new_key(rx_data)) begin
            cmd_valid = 1'b1;
            cmd_new   = 1'b1;
          end else if (kdir != DIR_NONE) begin
            cmd_valid = 1'b1;
            cmd_dir   = kdir;
          end
        end
      end
      P_ESC, P_CSI: begin
        if (rx_valid) begin
          tmo_nx   = '0;
          state_nx = P_IDLE;
          if (state == P_CSI) begin
            cmd_valid = (adir != DIR_NONE);
            cmd_dir   = adir;
          end else if (rx_data == KEY_CSI) begin
            state_nx = P_CSI;
          end else if (rx_data == KEY_ESC) begin
            state_nx = P_ESC;
          end
        end else if (tmo == TMO_LAST) begin
          tmo_nx   = '0;
          state_nx = P_IDLE;
        end else begin
          tmo_nx = tmo + 1'b1;
        end
      end
      default: begin
        state_nx = P_IDLE;
        tmo_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/move_cmd_decoder.sv
// Merges UART keys and button pulses into one-cycle 2048 move commands.
// Ports: clk, rst (async low), rx_*, btn_*, busy in; dir, new_game, drop_cnt out.
// Macro MOVE_CMD_DROP_CNT_EN builds drop_cnt; otherwise it is tied to 0.
module move_cmd_decoder
  import twenty48_pkg::*;
#(
  parameter int ESC_TIMEOUT = 100000,
  parameter int MIN_GAP     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_new,
  input  logic       busy,
  output logic [2:0] dir,
  output logic       new_game,
  output logic [7:0] drop_cnt
);

  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(MIN_GAP);

  logic          u_valid;
  logic          u_new;
  dir_t          u_dir;

  logic          win_v;
  logic          win_new;
  dir_t          win_dir;

  logic          ent_v;
  logic          ent_new;
  dir_t          ent_dir;
  logic [GW-1:0] gap;

  logic          issue;
  logic          free;
  logic          load;

  uart_key_parser #(
    .ESC_TIMEOUT(ESC_TIMEOUT)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .cmd_valid(u_valid),
    .cmd_new  (u_new),
    .cmd_dir  (u_dir)
  );

  always_comb begin
    win_v   = 1'b1;
    win_new = 1'b0;
    win_dir = DIR_NONE;
    if (btn_new) begin
      win_new = 1'b1;
    end else if (u_valid) begin
      win_new = u_new;
      win_dir = u_dir;
    end else if (btn_up) begin
      win_dir = DIR_UP;
    end else if (btn_right) begin
      win_dir = DIR_RIGHT;
    end else if (btn_down) begin
      win_dir = DIR_DOWN;
    end else if (btn_left) begin
      win_dir = DIR_LEFT;
    end else begin
      win_v = 1'b0;
    end
  end

  // An entry issuing this cycle frees the slot for the incoming winner.
  assign issue = ent_v & ~busy & (gap == '0);
  assign free  = ~ent_v | issue;
  assign load  = win_v & (win_new | free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_v    <= 1'b0;
      ent_new  <= 1'b0;
      ent_dir  <= DIR_NONE;
      gap      <= '0;
      dir      <= DIR_NONE;
      new_game <= 1'b0;
    end else begin
      if (load) begin
        ent_v   <= 1'b1;
        ent_new <= win_new;
        ent_dir <= win_dir;
      end else if (issue) begin
        ent_v <= 1'b0;
      end
      if (issue) begin
        gap <= GAP_LD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      dir      <= (issue & ~ent_new) ? ent_dir : DIR_NONE;
      new_game <= issue & ent_new;
    end
  end

`ifdef MOVE_CMD_DROP_CNT_EN
  logic [2:0] n_src;
  logic [2:0] lose;
  logic       buf_drop;
  logic [3:0] inc;
  logic [8:0] sum;
  logic [7:0] drop_q;

  assign n_src = {2'b0, btn_new} + {2'b0, u_valid}
               + {2'b0, btn_up} + {2'b0, btn_right}
               + {2'b0, btn_down} + {2'b0, btn_left};
  assign lose  = n_src - {2'b0, win_v};

  // New-game only costs a drop when it displaces a waiting move.
  assign buf_drop = win_v & (win_new
                  ? (ent_v & ~ent_new & ~issue)
                  : ~free);

  assign inc = {1'b0, lose} + {3'b0, buf_drop};
  assign sum = {1'b0, drop_q} + {5'b0, inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= sum[8] ? 8'hFF : sum[7:0];
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_move_cmd_decoder.sv
// Scoreboard bench for move_cmd_decoder with a behavioural reference model.
// Directed cases from the block's behaviour list, then random traffic.
module tb_move_cmd_decoder;

  localparam int TMO = 8;
  localparam int GAP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_new = 1'b0;
  logic       busy = 1'b0;
  logic [2:0] dir;
  logic       new_game;
  logic [7:0] drop_cnt;

  move_cmd_decoder #(
    .ESC_TIMEOUT(TMO),
    .MIN_GAP    (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .btn_up   (btn_up),
    .btn_right(btn_right),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_new  (btn_new),
    .busy     (busy),
    .dir      (dir),
    .new_game (new_game),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int edge_n;
    bit nw;
    int code;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n_mov = 0;
  int n_new = 0;
  int last_out = 0;
  int prev_out = 0;
  int last_dir = 4;

  // model: 0 idle, 1 after ESC, 2 after ESC [
  int m_mode;
  int m_idle;
  int m_gap;
  int m_drop;
  bit m_pv;
  bit m_pnew;
  int m_pcode;

  logic [7:0] tbl [0:17] = '{
    8'h77, 8'h61, 8'h73, 8'h64, 8'h57, 8'h41,
    8'h53, 8'h44, 8'h72, 8'h52, 8'h1B, 8'h1B,
    8'h5B, 8'h5B, 8'h42, 8'h43, 8'h78, 8'h00
  };

  function automatic int key_code(input logic [7:0] b);
    case (b)
      "w", "W": return 0;
      "d", "D": return 1;
      "s", "S": return 2;
      "a", "A": return 3;
      "r", "R": return 5;
      default:  return -1;
    endcase
  endfunction

  function automatic int arrow_code(input logic [7:0] b);
    case (b)
      "A":     return 0;
      "C":     return 1;
      "B":     return 2;
      "D":     return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_drop();
`ifdef MOVE_CMD_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  function automatic void model_clear();
    m_mode = 0;
    m_idle = 0;
    m_gap = 0;
    m_drop = 0;
    m_pv = 0;
    m_pnew = 0;
    m_pcode = 4;
  endfunction

  // Apply one clock edge worth of inputs to the model.
  function automatic void model_step();
    bit iss;
    int u;
    int w;
    int srcs[$];
    iss = m_pv && !busy && (m_gap == 0);
    if (iss) sb.push_back(exp_t'{cyc + 1, m_pnew, m_pcode});
    u = -1;
    if (rx_valid) begin
      m_idle = 0;
      if (m_mode == 0) begin
        if (rx_data == 8'h1B) m_mode = 1;
        else u = key_code(rx_data);
      end else if (m_mode == 1) begin
        if (rx_data == 8'h5B) m_mode = 2;
        else if (rx_data != 8'h1B) m_mode = 0;
      end else begin
        u = arrow_code(rx_data);
        m_mode = 0;
      end
    end else if (m_mode != 0) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_mode = 0;
        m_idle = 0;
      end
    end
    if (btn_new) srcs.push_back(5);
    if (u >= 0) srcs.push_back(u);
    if (btn_up) srcs.push_back(0);
    if (btn_right) srcs.push_back(1);
    if (btn_down) srcs.push_back(2);
    if (btn_left) srcs.push_back(3);
    w = -1;
    if (srcs.size() > 0) begin
      w = srcs[0];
      m_drop += srcs.size() - 1;
    end
    if (iss) m_gap = GAP;
    else if (m_gap > 0) m_gap--;
    if (iss) m_pv = 0;
    if (w == 5) begin
      if (m_pv && !m_pnew) m_drop++;
      m_pv = 1;
      m_pnew = 1;
      m_pcode = 4;
    end else if (w >= 0) begin
      if (m_pv) m_drop++;
      else begin
        m_pv = 1;
        m_pnew = 0;
        m_pcode = w;
      end
    end
    if (m_drop > 255) m_drop = 255;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && (dir != 3'd4 || new_game)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got dir=%0d new_game=%0b cyc=%0d, required none",
                   dir, new_game, cyc);
        end else begin
          e = sb.pop_front();
          if (e.edge_n != cyc || int'(dir) != e.code || new_game != e.nw) begin
            errors++;
            $display("FAIL out_match: got dir=%0d new_game=%0b cyc=%0d, required dir=%0d new_game=%0b cyc=%0d",
                     dir, new_game, cyc, e.code, e.nw, e.edge_n);
          end
        end
        if (new_game) n_new++;
        else n_mov++;
        prev_out = last_out;
        last_out = cyc;
        last_dir = int'(dir);
      end else if (rst && sb.size() > 0 && sb[0].edge_n <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL out_missing: got no output at cyc=%0d, required dir=%0d new_game=%0b",
                 cyc, e.code, e.nw);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("drop_cnt", int'(drop_cnt), exp_drop());
    rx_valid = 1'b0;
    btn_up = 1'b0;
    btn_right = 1'b0;
    btn_down = 1'b0;
    btn_left = 1'b0;
    btn_new = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    btn_up = 1'b0;
    btn_right = 1'b0;
    btn_down = 1'b0;
    btn_left = 1'b0;
    btn_new = 1'b0;
    busy = 1'b0;
    #1;
    chk("rst_dir", int'(dir), 4);
    chk("rst_new_game", int'(new_game), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    model_clear();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int base;
    int nb;
    int c0;
    model_clear();
    fork
      monitor();
    join_none
    #2;
    do_reset();

    base = n_mov;
    c0 = cyc;
    send("w");
    idle(6);
    chk("w_count", n_mov - base, 1);
    chk("w_dir", last_dir, 0);
    chk("w_latency", last_out - c0, 2);

    do_reset();
    base = n_mov;
    send(8'h1B);
    send(8'h5B);
    send(8'h43);
    idle(6);
    chk("arrow_count", n_mov - base, 1);
    chk("arrow_dir", last_dir, 1);

    do_reset();
    base = n_mov;
    send(8'h1B);
    send(8'h5B);
    idle(TMO + 1);
    send(8'h43);
    idle(6);
    chk("arrow_timeout_count", n_mov - base, 0);

    do_reset();
    base = n_mov;
    busy = 1'b1;
    send("a");
    send("d");
    idle(4);
    busy = 1'b0;
    idle(8);
    chk("busy_count", n_mov - base, 1);
    chk("busy_dir", last_dir, 3);
`ifdef MOVE_CMD_DROP_CNT_EN
    chk("busy_drop", int'(drop_cnt), 1);
`else
    chk("busy_drop", int'(drop_cnt), 0);
`endif

    do_reset();
    base = n_mov;
    nb = n_new;
    btn_up = 1'b1;
    send("R");
    idle(6);
    chk("newgame_count", n_new - nb, 1);
    chk("newgame_moves", n_mov - base, 0);
`ifdef MOVE_CMD_DROP_CNT_EN
    chk("newgame_drop", int'(drop_cnt), 1);
`else
    chk("newgame_drop", int'(drop_cnt), 0);
`endif

    do_reset();
    base = n_mov;
    send("s");
    idle(2);
    send("s");
    idle(20);
    chk("gap_count", n_mov - base, 2);
    chk("gap_spacing_ok", int'((last_out - prev_out) >= GAP), 1);

    do_reset();
    send("w");
    tick();
    do_reset();
    base = n_mov;
    busy = 1'b1;
    send("a");
    idle(2);
    do_reset();
    idle(20);
    chk("rst_pending_count", n_mov - base, 0);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      if ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b1;
        rx_data = tbl[$urandom_range(0, 17)];
      end
      btn_up = ($urandom_range(0, 24) == 0);
      btn_right = ($urandom_range(0, 24) == 0);
      btn_down = ($urandom_range(0, 24) == 0);
      btn_left = ($urandom_range(0, 24) == 0);
      btn_new = ($urandom_range(0, 60) == 0);
      tick();
      if (i % 400 == 200) idle(TMO + 2);
    end
    busy = 1'b0;
    idle(30);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_cmd_decoder.md
# move_cmd_decoder

Turns user input into single-cycle move commands for the 2048 game controller. It decodes UART keystrokes: WASD keys, R for a new game, and ANSI arrow-key escape sequences. It merges those with the debounced button pulses and arbitrates between them. Accepted commands are held in a one-entry buffer and released only while the board printer is idle. It sits between `uart_top`/`debouncer` and `gameController`, replacing the ad-hoc `dir_store` register at top level.

## Interface
Parameters:
- `ESC_TIMEOUT`, default 100000: idle cycles allowed inside an escape sequence before the parser aborts.
- `MIN_GAP`, default 16: minimum cycles between two issued commands.

Ports:
- `clk` input, 1: system clock. One clock domain.
- `rst` input, 1: asynchronous, active-low reset.
- `rx_data` input, 8: received byte from `uart_top`.
- `rx_valid` input, 1: one-cycle strobe qualifying `rx_data`.
- `btn_up`, `btn_right`, `btn_down`, `btn_left` input, 1 each: debounced one-cycle button pulses.
- `btn_new` input, 1: debounced new-game button pulse.
- `busy` input, 1: high while the board printer is still emitting characters (`~done`).
- `dir` output, 3: move command. 0=up, 1=right, 2=down, 3=left, 4=none. It is non-4 for exactly one cycle per issued move.
- `new_game` output, 1: one-cycle pulse requesting a board reset.
- `drop_cnt` output, 8: saturating count of discarded commands.

## Operation
- Single-byte keys (`rx_valid` high, parser in IDLE):
  - 'w'/'W' → up; 'd'/'D' → right; 's'/'S' → down; 'a'/'A' → left.
  - 'r'/'R' → new game.
  - Any other byte is ignored. Ignored bytes are not counted as drops.
- Escape-sequence parser states are IDLE, ESC and CSI.
  - IDLE: byte 0x1B → ESC.
  - ESC: '[' (0x5B) → CSI. 0x1B stays in ESC. Any other byte → IDLE, and that byte is discarded.
  - CSI: 'A' → up, 'B' → down, 'C' → right, 'D' → left, then → IDLE. Any other byte → IDLE.
  - In ESC or CSI, `ESC_TIMEOUT` consecutive cycles without `rx_valid` → IDLE. The timeout counter reloads on every byte.
- Arbitration, when several command sources fire in one cycle:
  - Priority order: `btn_new` > UART-decoded command > `btn_up` > `btn_right` > `btn_down` > `btn_left`.
  - Only the winner is offered to the buffer. Each loser increments `drop_cnt`.
- Pending buffer (one entry: valid bit plus code):
  - Empty: the winner is loaded.
  - Full holding a move, winner is a move: the new move is dropped and `drop_cnt` increments.
  - A new-game winner always overwrites the entry. If a move was overwritten, `drop_cnt` increments.
- Issue:
  - Condition: entry valid, `busy`=0, and gap counter = 0.
  - On issue, drive `dir`=code (or pulse `new_game`), clear the entry and load the gap counter with `MIN_GAP`.
  - The gap counter decrements to 0 and holds there.
- `drop_cnt` saturates at 255. It is 8-bit unsigned.

## Timing
- Reset values: `dir`=4, `new_game`=0, `drop_cnt`=0. Parser state IDLE, buffer empty, gap counter 0, timeout counter 0.
- Latency with `busy`=0 and gap counter 0:
  - `rx_valid` or a button pulse sampled at edge N loads the buffer at edge N.
  - `dir`/`new_game` are registered and become visible after edge N+1 (2-cycle latency).
- For an arrow key, latency is counted from the final byte.
- A load and an issue in the same cycle are allowed. The issued entry leaves and the new winner loads, so there is no spurious drop.
- If `busy` rises on the issue cycle, the issue still completes. `busy` is sampled, not edge-detected.
- If reset asserts mid-sequence or with a command pending, everything returns to reset values immediately (asynchronous). A partially received escape sequence is lost.

## Configuration
- `MOVE_CMD_DROP_CNT_EN` defined: the drop counter is built as described above.
- Not defined: the counter logic is omitted and `drop_cnt` is tied to 0. Command behaviour is otherwise identical.

## Structure
- Shared package `twenty48_pkg` holds:
  - `DIR_UP`=0, `DIR_RIGHT`=1, `DIR_DOWN`=2, `DIR_LEFT`=3, `DIR_NONE`=4.
  - A 3-bit direction type.
  - ASCII constants: `KEY_ESC`=0x1B and `KEY_CSI`=0x5B.
- Sub-module `uart_key_parser`: the IDLE/ESC/CSI state machine plus the timeout counter. It outputs a one-cycle decoded-command valid with a code. Arbitration, the buffer, the gap counter and `drop_cnt` stay in the top of this block.

## Test plan
- Byte 'w', idle: `dir`=0 for exactly one cycle, 2 cycles after `rx_valid`; otherwise `dir`=4.
- Bytes 0x1B, 0x5B, 0x43, then `busy` low: `dir`=1 once. The same sequence with a gap of `ESC_TIMEOUT`+1 cycles before 0x43: no command.
- `busy` high; 'a' then 'd': `dir`=3 is issued after `busy` falls, 'd' is dropped and `drop_cnt`=1.
- `btn_up` and byte 'R' in the same cycle: `new_game` pulses, no move is issued, `drop_cnt`=1.
- 's' then 's' 3 cycles later, `busy` low: the second `dir`=2 appears at least `MIN_GAP` cycles after the first.
- Assert `rst` low with a command pending: outputs go to reset values at once and nothing issues after release.
